matrix_bcd_buffer: RTL and testbench
====================================

# matrix_bcd_buffer

Upstream feeder for the VGA matrix display: accepts the nine binary result entries of a 3x3 matrix, converts each to three BCD digits with a sequential shift-add-3 (double-dabble) converter, and holds them in a shadow buffer. On a commit request, the shadow buffer is copied to the display buffer at the next vertical-blanking start, so a frame never shows a half-updated matrix. The display buffer drives the per-digit `bcd` inputs of the digit renderers as one flat bus.

## Interface
- `VAL_W`, default 10: width of binary input values; the converter runs `VAL_W` iterations.
- `N_ENT`, default 9: number of matrix entries, row-major, index = 3*row + col.
- `clk`, input, 1: system clock (same clock as the VGA counters).
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `wr_valid`, input, 1: write request.
- `wr_ready`, output, 1: block can accept a write.
- `wr_idx`, input, 4: target entry index.
- `wr_data`, input, `VAL_W`: unsigned value to display.
- `commit`, input, 1: single-cycle request to publish the shadow buffer.
- `vblank`, input, 1: vertical blanking from the vertical counter.
- `bcd_flat`, output, 12*`N_ENT`: display buffer. Entry i occupies [12i+11:12i]: hundreds [12i+11:12i+8], tens [12i+7:12i+4], ones [12i+3:12i].
- `busy`, output, 1: conversion in progress, or a commit is pending.
- `sat`, output, 1: one-cycle pulse when an accepted value exceeded 999.
- `idx_err`, output, 1: one-cycle pulse when a write is dropped because `wr_idx >= N_ENT`.
- `frame_done`, output, 1: one-cycle pulse in the cycle after the display buffer is updated.

## Operation
- **FSM states:** IDLE, CONV, STORE.
- **`wr_ready`:** equals (state == IDLE).
- **Handshake:** a handshake occurs on a clock edge where `wr_valid && wr_ready` is true.
- **Invalid index:** if `wr_idx >= N_ENT`, pulse `idx_err` in the next cycle, stay in IDLE, and leave the buffers unchanged.
- **Valid index:** capture `wr_idx`. Capture `wr_data` saturated to 999; if it was saturated, pulse `sat`. Clear the 12-bit BCD accumulator, set iteration counter = 0, go to CONV.
- **CONV, each cycle:**
  - Add 3 to every BCD nibble that is >= 5.
  - Shift {BCD, value} left by 1.
  - Increment the counter.
  - After `VAL_W` iterations, go to STORE.
- **STORE:** write the accumulator to shadow entry `idx`, go to IDLE.
- **Commit request:**
  - `commit` sets the registered flag `commit_pend`.
  - `commit` while the flag is already set has no further effect.
- **vblank edge detect:** `vblank` is registered once; a rise is `vblank && !vblank_q`.
- **Publish:**
  - Publish happens on a rise when `commit_pend` is set and state == IDLE.
  - All `N_ENT` shadow entries are copied to the display buffer in one cycle, `commit_pend` is cleared, and `frame_done` pulses in the following cycle.
  - A rise while in CONV or STORE does not publish; the commit waits for a later rise.
- **Same cycle as a rise:** `commit` in the same cycle as a rise does not publish on that rise; the earliest publish is the next rise.
- **Write during publish:** a handshake in the same cycle as a publish is accepted. The publish copies the shadow contents as they were before that write.
- **`busy`:** equals (state != IDLE) || `commit_pend`.
- **Reset, including mid-conversion:**
  - State goes to IDLE; shadow, display buffer and counter go to 0.
  - `commit_pend`, `sat`, `idx_err`, `frame_done` go to 0.
  - Any partial conversion is discarded.

## Timing
- **Reset values:** `bcd_flat` = 0, `wr_ready` = 1, `busy` = 0, `sat` = 0, `idx_err` = 0, `frame_done` = 0.
- **Valid handshake at edge T:**
  - CONV occupies cycles T+1..T+`VAL_W`.
  - STORE occupies cycle T+`VAL_W`+1.
  - The shadow entry updates at the end of that cycle.
  - `wr_ready` is high again from cycle T+`VAL_W`+2, which is T+12 at the default width.
- **Throughput:** one entry per `VAL_W`+2 cycles.
- **Flag pulses:** `sat` and `idx_err` are high during cycle T+1 only.
- **`bcd_flat`:** changes only on a publish edge; it is stable between vblank rises.
- **Latency:** from a write, through commit, to `bcd_flat` is bounded by the conversion time plus up to one frame.

## Test plan
- **Single value:** write idx 0 = 123, commit, raise `vblank` -> `bcd_flat[11:0]` = 12'h123, one `frame_done` pulse, all other entries 0.
- **Saturation:** write idx 8 = 1023 -> `sat` pulses at T+1; after commit and a vblank rise, `bcd_flat[107:96]` = 12'h999.
- **Invalid index:** write idx 9 = 5 -> `idx_err` pulses, `wr_ready` stays high, no change to any entry after commit.
- **Full matrix, back-to-back:** write 0, 7, 10, 99, 100, 250, 512, 999, 1 to idx 0..8 -> `wr_ready` low exactly 11 cycles after each handshake; after publish, `bcd_flat` = {12'h001, 12'h999, 12'h512, 12'h250, 12'h100, 12'h099, 12'h010, 12'h007, 12'h000}.
- **Commit timing:**
  - Raise vblank while in CONV with a commit pending -> no publish on that rise, publish on the next rise.
  - Assert `commit` on the same cycle as a rise -> no publish until the next rise.
- **Reset mid-conversion:** assert `reset_n` = 0 during CONV -> all outputs return to their reset values immediately, `wr_ready` = 1 after release, and a subsequent write plus commit behaves normally.

Source files
------------

// File: rtl/matrix_bcd_buffer.sv
// Shadow/display buffer feeding the VGA matrix digit renderers: converts each
// binary entry to three BCD digits and publishes the whole matrix at vblank start.
module matrix_bcd_buffer #(
   parameter int VAL_W = 10,
   parameter int N_ENT = 9
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [3:0]             wr_idx,
   input  logic [VAL_W-1:0]       wr_data,
   input  logic                   commit,
   input  logic                   vblank,
   output logic [12*N_ENT-1:0]    bcd_flat,
   output logic                   busy,
   output logic                   sat,
   output logic                   idx_err,
   output logic                   frame_done
);

   localparam int CNT_W = $clog2(VAL_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CONV  = 2'd1;
   localparam logic [1:0] S_STORE = 2'd2;

   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(VAL_W - 1);
   localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(999);

   logic [1:0]            state;
   logic [3:0]            idx_q;
   logic [VAL_W-1:0]      val_q;
   logic [11:0]           acc_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [11:0]           shadow [N_ENT];
   logic [12*N_ENT-1:0]   disp_q;
   logic                  commit_pend;
   logic                  vblank_q;
   logic                  sat_q;
   logic                  idx_err_q;
   logic                  frame_done_q;

   logic                  idx_ok;
   logic                  vblank_rise;
   logic                  publish;
   logic [11:0]           acc_adj;
   logic [11:0]           acc_nxt;
   logic [VAL_W-1:0]      val_nxt;
   logic [12*N_ENT-1:0]   shadow_flat;

   assign idx_ok      = {28'd0, wr_idx} < 32'(N_ENT);
   assign vblank_rise = vblank && !vblank_q;
   // commit_pend is the registered flag, so a commit arriving with the rise waits a frame
   assign publish     = vblank_rise && commit_pend && (state == S_IDLE);

   // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      acc_adj = acc_q;
      for (int k = 0; k < 3; k++) begin
         if (acc_q[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
   end

   assign {acc_nxt, val_nxt} = {acc_adj[10:0], val_q, 1'b0};

   always_comb begin
      shadow_flat = '0;
      for (int i = 0; i < N_ENT; i++) shadow_flat[12*i +: 12] = shadow[i];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         idx_q        <= '0;
         val_q        <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         disp_q       <= '0;
         commit_pend  <= 1'b0;
         vblank_q     <= 1'b0;
         sat_q        <= 1'b0;
         idx_err_q    <= 1'b0;
         frame_done_q <= 1'b0;
         // NOTE: the shadow array is small and must read as zero after reset, so it is reset explicitly.
         for (int i = 0; i < N_ENT; i++) shadow[i] <= '0;
      end else begin
         sat_q        <= 1'b0;
         idx_err_q    <= 1'b0;
         frame_done_q <= publish;
         vblank_q     <= vblank;

         case (state)
            S_IDLE: begin
               if (wr_valid) begin
                  if (idx_ok) begin
                     idx_q <= wr_idx;
                     if (32'(wr_data) > 32'd999) begin
                        val_q <= MAX_VAL;
                        sat_q <= 1'b1;
                     end else begin
                        val_q <= wr_data;
                     end
                     acc_q <= '0;
                     cnt_q <= '0;
                     state <= S_CONV;
                  end else begin
                     idx_err_q <= 1'b1;
                  end
               end
            end
            S_CONV: begin
               acc_q <= acc_nxt;
               val_q <= val_nxt;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_IT) state <= S_STORE;
            end
            S_STORE: begin
               for (int i = 0; i < N_ENT; i++) begin
                  if (idx_q == 4'(i)) shadow[i] <= acc_q;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // a publish clears the flag even if commit is repeated in that cycle
         if (publish) begin
            disp_q      <= shadow_flat;
            commit_pend <= 1'b0;
         end else if (commit) begin
            commit_pend <= 1'b1;
         end
      end
   end

   assign wr_ready   = (state == S_IDLE);
   assign busy       = (state != S_IDLE) || commit_pend;
   assign sat        = sat_q;
   assign idx_err    = idx_err_q;
   assign frame_done = frame_done_q;
   assign bcd_flat   = disp_q;

endmodule

// File: tb/tb_matrix_bcd_buffer.sv
// Self-checking bench for matrix_bcd_buffer: table of writes plus hand-built
// commit/vblank and reset sequences, publishes checked through a scoreboard queue.
module tb_matrix_bcd_buffer;

   localparam int VAL_W = 10;
   localparam int N_ENT = 9;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [3:0]            wr_idx;
   logic [VAL_W-1:0]      wr_data;
   logic                  commit;
   logic                  vblank;
   logic [12*N_ENT-1:0]   bcd_flat;
   logic                  busy;
   logic                  sat;
   logic                  idx_err;
   logic                  frame_done;

   matrix_bcd_buffer #(.VAL_W(VAL_W), .N_ENT(N_ENT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .commit     (commit),
      .vblank     (vblank),
      .bcd_flat   (bcd_flat),
      .busy       (busy),
      .sat        (sat),
      .idx_err    (idx_err),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]       idx;
      logic [VAL_W-1:0] data;
      logic [11:0]      bcd;
      logic             sat;
      logic             err;
   } vec_t;

   vec_t                vecs [9];
   int                  n_tests = 0;
   int                  n_fail  = 0;
   logic [11:0]         exp_shadow [N_ENT];
   logic [12*N_ENT-1:0] cur_disp = '0;
   logic [12*N_ENT-1:0] sb [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [12*N_ENT-1:0] model_flat();
      logic [12*N_ENT-1:0] f;
      f = '0;
      for (int i = 0; i < N_ENT; i++) f[12*i +: 12] = exp_shadow[i];
      return f;
   endfunction

   // publish monitor: every frame_done pops one expected display image
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (frame_done) begin
               if (sb.size() == 0) begin
                  check("unexpected frame_done", {127'd0, frame_done}, 128'd0);
               end else begin
                  cur_disp = sb.pop_front();
                  check("publish bcd_flat", 128'(bcd_flat), 128'(cur_disp));
               end
            end else begin
               check("bcd_flat stable", 128'(bcd_flat), 128'(cur_disp));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [3:0] idx, input logic [VAL_W-1:0] data,
                           input logic exp_sat, input logic exp_err, input logic [11:0] exp_bcd);
      int n;
      n = 0;
      while (!wr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wr_ready before write", {127'd0, wr_ready}, 128'd1);
      wr_valid = 1'b1;
      wr_idx   = idx;
      wr_data  = data;
      @(negedge clk);
      wr_valid = 1'b0;
      check("sat pulse", {127'd0, sat}, {127'd0, exp_sat});
      check("idx_err pulse", {127'd0, idx_err}, {127'd0, exp_err});
      if (exp_err) begin
         check("wr_ready after bad idx", {127'd0, wr_ready}, 128'd1);
      end else begin
         n = 0;
         while (!wr_ready && n < 40) begin
            n++;
            @(negedge clk);
         end
         check("wr_ready low cycles", 128'(n), 128'(VAL_W + 1));
         check("sat cleared", {127'd0, sat}, 128'd0);
         exp_shadow[idx] = exp_bcd;
      end
   endtask

   task automatic do_commit();
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
   endtask

   task automatic vblank_pulse(input logic expect_pub);
      vblank = 1'b1;
      if (expect_pub) sb.push_back(model_flat());
      repeat (3) @(negedge clk);
      vblank = 1'b0;
      @(negedge clk);
      check("publish queue drained", 128'(sb.size()), 128'd0);
   endtask

   initial begin
      logic [12*N_ENT-1:0] full_exp;
      int n;

      vecs[0] = '{4'd0, 10'd0,    12'h000, 1'b0, 1'b0};
      vecs[1] = '{4'd1, 10'd7,    12'h007, 1'b0, 1'b0};
      vecs[2] = '{4'd2, 10'd10,   12'h010, 1'b0, 1'b0};
      vecs[3] = '{4'd3, 10'd99,   12'h099, 1'b0, 1'b0};
      vecs[4] = '{4'd4, 10'd100,  12'h100, 1'b0, 1'b0};
      vecs[5] = '{4'd5, 10'd250,  12'h250, 1'b0, 1'b0};
      vecs[6] = '{4'd6, 10'd512,  12'h512, 1'b0, 1'b0};
      vecs[7] = '{4'd7, 10'd999,  12'h999, 1'b0, 1'b0};
      vecs[8] = '{4'd8, 10'd1,    12'h001, 1'b0, 1'b0};
      full_exp = {12'h001, 12'h999, 12'h512, 12'h250, 12'h100,
                  12'h099, 12'h010, 12'h007, 12'h000};
      for (int i = 0; i < N_ENT; i++) exp_shadow[i] = '0;

      reset_n = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_data = '0; commit = 1'b0; vblank = 1'b0;
      repeat (2) @(negedge clk);
      check("reset bcd_flat", 128'(bcd_flat), 128'd0);
      check("reset wr_ready", {127'd0, wr_ready}, 128'd1);
      check("reset busy", {127'd0, busy}, 128'd0);
      check("reset sat", {127'd0, sat}, 128'd0);
      check("reset idx_err", {127'd0, idx_err}, 128'd0);
      check("reset frame_done", {127'd0, frame_done}, 128'd0);
      #3 reset_n = 1'b1;
      @(negedge clk);

      // single value
      do_write(4'd0, 10'd123, 1'b0, 1'b0, 12'h123);
      do_commit();
      check("busy with commit pending", {127'd0, busy}, 128'd1);
      vblank_pulse(1'b1);
      check("single entry 0", 128'(bcd_flat[11:0]), 128'h123);
      check("busy after publish", {127'd0, busy}, 128'd0);

      // saturation
      do_write(4'd8, 10'd1023, 1'b1, 1'b0, 12'h999);
      do_commit();
      vblank_pulse(1'b1);
      check("saturated entry 8", 128'(bcd_flat[107:96]), 128'h999);

      // invalid index leaves every entry alone
      do_write(4'd9, 10'd5, 1'b0, 1'b1, 12'h000);
      do_commit();
      vblank_pulse(1'b1);

      // full matrix, back-to-back from the table
      for (int i = 0; i < 9; i++)
         do_write(vecs[i].idx, vecs[i].data, vecs[i].sat, vecs[i].err, vecs[i].bcd);
      do_commit();
      vblank_pulse(1'b1);
      check("full matrix", 128'(bcd_flat), 128'(full_exp));

      // rise during CONV with a commit pending must wait for the next rise
      do_commit();
      wr_valid = 1'b1; wr_idx = 4'd4; wr_data = 10'd321;
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      check("busy in CONV", {127'd0, busy}, 128'd1);
      check("wr_ready low in CONV", {127'd0, wr_ready}, 128'd0);
      vblank_pulse(1'b0);
      n = 0;
      while (!wr_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("conversion finished", {127'd0, wr_ready}, 128'd1);
      exp_shadow[4] = 12'h321;
      check("commit still pending", {127'd0, busy}, 128'd1);
      vblank_pulse(1'b1);
      check("entry 4 after late publish", 128'(bcd_flat[59:48]), 128'h321);

      // commit in the same cycle as a rise
      do_write(4'd1, 10'd42, 1'b0, 1'b0, 12'h042);
      commit = 1'b1;
      vblank = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      @(negedge clk);
      check("pending after same-cycle commit", {127'd0, busy}, 128'd1);
      vblank = 1'b0;
      @(negedge clk);
      vblank_pulse(1'b1);
      check("entry 1 after next rise", 128'(bcd_flat[23:12]), 128'h042);

      // reset in the middle of a conversion
      do_commit();
      wr_valid = 1'b1; wr_idx = 4'd2; wr_data = 10'd555;
      @(negedge clk);
      wr_valid = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      cur_disp = '0;
      for (int i = 0; i < N_ENT; i++) exp_shadow[i] = '0;
      reset_n = 1'b0;
      #1;
      check("mid reset bcd_flat", 128'(bcd_flat), 128'd0);
      check("mid reset wr_ready", {127'd0, wr_ready}, 128'd1);
      check("mid reset busy", {127'd0, busy}, 128'd0);
      check("mid reset frame_done", {127'd0, frame_done}, 128'd0);
      repeat (2) @(negedge clk);
      #3 reset_n = 1'b1;
      @(negedge clk);
      check("after reset wr_ready", {127'd0, wr_ready}, 128'd1);
      check("after reset busy", {127'd0, busy}, 128'd0);
      do_write(4'd2, 10'd555, 1'b0, 1'b0, 12'h555);
      do_commit();
      vblank_pulse(1'b1);
      check("post-reset publish", 128'(bcd_flat), 128'(model_flat()));

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
